// File: rtl/angle_calc_pkg.sv
// rtl/angle_calc_pkg.sv - register map, FSM encodings and byte-lane merge helper for the angle core AXI4-Lite slave
package angle_calc_pkg;

    localparam int NUM_REGS = 4;

    // Word indices, taken from byte address bits [3:2] (offsets 0x0, 0x4, 0x8, 0xC)
    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_ANGLE_IN = 2'd1;
    localparam logic [1:0] REG_PARAM    = 2'd2;
    localparam logic [1:0] REG_SCRATCH  = 2'd3;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) merged[8*b +: 8] = new_v[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/angle_calc_axil_slave.sv
// rtl/angle_calc_axil_slave.sv - AXI4-Lite register slave exposing CTRL/ANGLE_IN/PARAM/SCRATCH to the angle core
module angle_calc_axil_slave
    import angle_calc_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_o,
    output logic [NUM_REGS-1:0]               wr_pulse_o
);

    w_state_t                          r_wstate;
    r_state_t                          r_rstate;
    logic                              r_awready, r_wready, r_bvalid;
    logic                              r_arready, r_rvalid;
    logic                              r_aw_held, r_w_held;
    logic [1:0]                        r_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   r_wstrb;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_rdata;
    logic [NUM_REGS-1:0]               r_wr_pulse;
    logic [C_S_AXI_DATA_WIDTH-1:0]     r_regs      [NUM_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_regs_next [NUM_REGS];

    logic                              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [1:0]                        w_aw_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]     w_wdata_sel;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   w_wstrb_sel;
    logic                              w_unused;

    assign w_aw_hs = s00_axi_awvalid & r_awready;
    assign w_w_hs  = s00_axi_wvalid  & r_wready;
    assign w_ar_hs = s00_axi_arvalid & r_arready;

    // Commit as soon as the second half arrives so a read accepted in that cycle sees the new value
    assign w_aw_idx    = r_aw_held ? r_aw_idx : s00_axi_awaddr[3:2];
    assign w_wdata_sel = r_w_held  ? r_wdata  : s00_axi_wdata;
    assign w_wstrb_sel = r_w_held  ? r_wstrb  : s00_axi_wstrb;
    assign w_commit    = (r_wstate == W_IDLE) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);

    always_comb begin
        w_regs_next = r_regs;
        if (w_commit) begin
            w_regs_next[w_aw_idx] = apply_wstrb(r_regs[w_aw_idx], w_wdata_sel, w_wstrb_sel);
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_bvalid   <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_aw_idx   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_wr_pulse <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            r_wr_pulse <= '0;
            r_regs     <= w_regs_next;
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        if (|w_wstrb_sel) r_wr_pulse <= 4'b0001 << w_aw_idx;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_bvalid  <= 1'b1;
                        r_wstate  <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_aw_idx  <= s00_axi_awaddr[3:2];
                            r_awready <= 1'b0;
                        end else if (!r_aw_held) begin
                            r_awready <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s00_axi_wdata;
                            r_wstrb  <= s00_axi_wstrb;
                            r_wready <= 1'b0;
                        end else if (!r_w_held) begin
                            r_wready <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    // Readies re-arm one cycle after the response retires
                    if (s00_axi_bready) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_regs_next[s00_axi_araddr[3:2]];
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s00_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s00_axi_awready = r_awready;
    assign s00_axi_wready  = r_wready;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = RESP_OKAY;
    assign s00_axi_arready = r_arready;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rdata   = r_rdata;
    assign s00_axi_rresp   = RESP_OKAY;
    assign wr_pulse_o      = r_wr_pulse;
    assign reg_o = {r_regs[REG_SCRATCH], r_regs[REG_PARAM], r_regs[REG_ANGLE_IN], r_regs[REG_CTRL]};

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_angle_calc_axil_slave.sv
// tb/tb_angle_calc_axil_slave.sv - table-driven and sequence checks of angle_calc_axil_slave with a read scoreboard
module tb_angle_calc_axil_slave;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   awaddr, araddr;
    logic [2:0]   awprot, arprot;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic         arvalid, arready, rvalid, rready;
    logic [127:0] reg_o;
    logic [3:0]   wr_pulse;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] sb_q[$];
    logic [31:0] mon_exp;
    logic [31:0] tb_regs [4];

    typedef struct {
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  raddr;
        logic [31:0] rexp;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    angle_calc_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
        .s00_axi_aclk(clk),        .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr),   .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),     .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),   .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),     .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),   .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),   .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready), .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),     .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),   .reg_o(reg_o),
        .wr_pulse_o(wr_pulse)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_vec();
        return {tb_regs[3], tb_regs[2], tb_regs[1], tb_regs[0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = o;
        for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = n[8*b +: 8];
        return m;
    endfunction

    // Scoreboard: every read data beat is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n && rvalid && rready) begin
            if (sb_q.size() == 0) begin
                check("r_unexpected", 1'b1, 1'b0);
            end else begin
                mon_exp = sb_q.pop_front();
                check("rdata", {rresp, rdata}, {2'b00, mon_exp});
            end
        end
    end

    task automatic send_aw_w(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        bit aw_done = 0;
        bit w_done  = 0;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 40) begin
            if (awvalid && awready) aw_done = 1;
            if (wvalid && wready) w_done = 1;
            @(posedge clk); #1;
            if (aw_done) awvalid = 1'b0;
            if (w_done) wvalid = 1'b0;
            n++;
        end
        check("aw_w_accepted", {aw_done, w_done}, 2'b11);
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic wait_b();
        int n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bvalid_seen", bvalid, 1'b1);
        check("bresp", bresp, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic axi_read(input logic [3:0] a, input logic [31:0] e);
        int n = 0;
        sb_q.push_back(e);
        araddr = a; arvalid = 1'b1;
        while (!arready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ar_accepted", arready, 1'b1);
        @(posedge clk); #1;
        arvalid = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            check("r_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int good;
        int n;
        bit seen_b;
        bit acc;

        vecs[0] = '{4'h0, 32'h0101FFFF, 4'hF, 4'h0, 32'h0101FFFF};
        vecs[1] = '{4'h4, 32'hABCD0001, 4'hF, 4'h4, 32'hABCD0001};
        vecs[2] = '{4'h8, 32'hDEAD0011, 4'hF, 4'h8, 32'hDEAD0011};
        vecs[3] = '{4'hC, 32'hBEEF0011, 4'hF, 4'hC, 32'hBEEF0011};
        vecs[4] = '{4'h8, 32'hFFFFFFFF, 4'hF, 4'h8, 32'hFFFFFFFF};
        vecs[5] = '{4'h8, 32'h00000000, 4'h5, 4'h8, 32'hFF00FF00};
        vecs[6] = '{4'hC, 32'h11111111, 4'h0, 4'hC, 32'hBEEF0011};
        vecs[7] = '{4'h7, 32'h13572468, 4'hF, 4'h4, 32'h13572468};
        for (int i = 0; i < 4; i++) tb_regs[i] = '0;

        rst_n = 1'b0;
        awaddr = '0; araddr = '0; awprot = 3'b010; arprot = 3'b001;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = '0; wstrb = '0; bready = 1'b1; rready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp}, '0);
        check("reset_reg_o", reg_o, '0);
        check("reset_rdata", rdata, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            send_aw_w(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb);
            wait_b();
            tb_regs[vecs[i].waddr[3:2]] = merge(tb_regs[vecs[i].waddr[3:2]], vecs[i].wdata, vecs[i].wstrb);
            check("vec_reg_o", reg_o, model_vec());
            axi_read(vecs[i].raddr, vecs[i].rexp);
        end

        // W leads AW by three cycles
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        n = 0;
        while (!wready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("w_first_ready", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("w_held_no_b", {bvalid, wready, wr_pulse}, '0);
        awaddr = 4'h4; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        check("late_aw_bvalid", bvalid, 1'b1);
        check("late_aw_reg", reg_o[63:32], 32'h12345678);
        check("late_aw_pulse", wr_pulse, 4'b0010);
        @(posedge clk); #1;
        check("pulse_one_cycle", {wr_pulse, bvalid}, '0);
        tb_regs[1] = 32'h12345678;

        // bready held low: second write must wait for the B handshake
        bready = 1'b0;
        send_aw_w(4'h0, 32'hCAFE0001, 4'hF);
        awaddr = 4'h0; wdata = 32'h0000BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        good = 0;
        repeat (10) begin
            if (bvalid && !awready && !wready) good++;
            @(posedge clk); #1;
        end
        check("b_hold_cycles", good, 10);
        check("ctrl_before_b", reg_o[31:0], 32'hCAFE0001);
        bready = 1'b1;
        send_aw_w(4'h0, 32'h0000BEEF, 4'hF);
        wait_b();
        tb_regs[0] = 32'h0000BEEF;
        check("second_write_reg_o", reg_o, model_vec());

        // Read and write of SCRATCH accepted in the same cycle
        repeat (2) @(posedge clk);
        #1;
        sb_q.push_back(32'hA5A5A5A5);
        awaddr = 4'hC; wdata = 32'hA5A5A5A5; wstrb = 4'hF; araddr = 4'hC;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        check("concurrent_ready", {awready, wready, arready}, 3'b111);
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wait_b();
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("concurrent_r_done", sb_q.size(), 0);
        sb_q.delete();
        tb_regs[3] = 32'hA5A5A5A5;
        check("concurrent_reg_o", reg_o, model_vec());

        // Reset between AW and W acceptance
        awaddr = 4'h4; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        awvalid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_ctrl", {awready, wready, arready, bvalid, rvalid, wr_pulse, bresp, rresp}, '0);
        check("midrst_reg_o", reg_o, '0);
        check("midrst_rdata", rdata, '0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tb_regs[i] = '0;
        wdata = 32'h99999999; wstrb = 4'hF; wvalid = 1'b1;
        seen_b = 0;
        repeat (10) begin
            if (bvalid) seen_b = 1;
            acc = wvalid && wready;
            @(posedge clk); #1;
            if (acc) wvalid = 1'b0;
        end
        wvalid = 1'b0;
        check("no_b_after_reset", seen_b, 1'b0);
        check("postrst_reg_o", reg_o, model_vec());
        for (int i = 0; i < 4; i++) begin
            logic [3:0] a;
            a = 4'(i * 4);
            axi_read(a, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
